// File: rtl/sd_dat_tx.sv
// sd_dat_tx: host-to-card write serializer on SD DAT0.
// It drains 32-bit words from the ADMA data FIFO and sends each block as a
// start bit, the data MSB first, a CRC16 and an end bit. If the FIFO runs dry
// in the middle of a block, the block raises sd_clk_stop and holds DAT steady
// rather than sending a corrupt bit.
//
// Ports:
//   CLK, RESET_L     clock and asynchronous active-low reset
//   start            one-cycle pulse that begins a transfer (used only when idle)
//   block_size       bytes per block, latched on start (low 2 bits ignored)
//   block_count      number of blocks, latched on start
//   data_from_fifo   FIFO read data, valid the cycle after fifo_read
//   fifo_empty       the FIFO holds no words
//   fifo_read        pop request to the FIFO
//   dat_out, dat_oe  DAT0 value and output enable
//   sd_clk_stop      gates the card clock during an underrun
//   busy, done       busy outside IDLE; done pulses once at the end of a transfer
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | pop the first word of a block (waits while the FIFO is empty)
// START  | start bit; load the shift register and clear the CRC
// DATA   | shift data bits out and prefetch the next word
// STALL  | underrun between words; card clock stopped
// RELOAD | load the word popped in STALL
// CRC    | 16 CRC bits, MSB first
// END    | end bit
// GAP    | idle-high DAT between blocks
// FINISH | done pulse
module sd_dat_tx #(
   parameter int GAP_CYCLES = 2,
   parameter int BLK_SIZE_W = 12
) (
   input  logic                  CLK,
   input  logic                  RESET_L,
   input  logic                  start,
   input  logic [BLK_SIZE_W-1:0] block_size,
   input  logic [15:0]           block_count,
   input  logic [31:0]           data_from_fifo,
   input  logic                  fifo_empty,
   output logic                  fifo_read,
   output logic                  dat_out,
   output logic                  dat_oe,
   output logic                  sd_clk_stop,
   output logic                  busy,
   output logic                  done
);

   localparam int WW       = BLK_SIZE_W - 2;
   localparam int GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
   localparam int GAP_LOAD = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_START  = 4'd2;
   localparam logic [3:0] S_DATA   = 4'd3;
   localparam logic [3:0] S_STALL  = 4'd4;
   localparam logic [3:0] S_RELOAD = 4'd5;
   localparam logic [3:0] S_CRC    = 4'd6;
   localparam logic [3:0] S_END    = 4'd7;
   localparam logic [3:0] S_GAP    = 4'd8;
   localparam logic [3:0] S_FINISH = 4'd9;

   logic [3:0]    r_state;
   logic [31:0]   r_shreg;
   logic [15:0]   r_crc;
   logic [4:0]    r_bit_cnt;
   logic [3:0]    r_crc_cnt;
   logic [WW-1:0] r_blk_words;
   logic [WW-1:0] r_words_left;
   logic [15:0]   r_blocks_left;
   logic [GW-1:0] r_gap_cnt;
   logic          r_pref;
   logic          r_last_bit;

   logic          w_pref_req;
   logic          w_crc_fb;
   logic [15:0]   w_crc_next;
   logic [WW-1:0] w_words_init;
   logic          w_unused_size_lsbs;

   // A partial trailing word is dropped: only whole words are counted.
   assign w_unused_size_lsbs = ^block_size[1:0];
   assign w_words_init = (r_blk_words == '0) ? '0 : r_blk_words - WW'(1);

   assign w_crc_fb   = r_crc[15] ^ r_shreg[31];
   assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);

   // Pop the next word one bit early so it arrives exactly as bit 0 leaves.
   assign w_pref_req = (r_state == S_DATA) && (r_bit_cnt == 5'd1) &&
                       (r_words_left != '0) && !fifo_empty;

   always_comb begin
      fifo_read   = w_pref_req ||
                    (((r_state == S_FETCH) || (r_state == S_STALL)) && !fifo_empty);
      sd_clk_stop = (r_state == S_STALL) || (r_state == S_RELOAD) ||
                    ((r_state == S_FETCH) && fifo_empty);
      dat_oe      = (r_state == S_START) || (r_state == S_DATA) ||
                    (r_state == S_STALL) || (r_state == S_RELOAD) ||
                    (r_state == S_CRC)   || (r_state == S_END);
      busy        = (r_state != S_IDLE);
      done        = (r_state == S_FINISH);
      dat_out     = 1'b1;
      case (r_state)
         S_START:           dat_out = 1'b0;
         S_DATA:            dat_out = r_shreg[31];
         S_STALL, S_RELOAD: dat_out = r_last_bit;
         S_CRC:             dat_out = r_crc[15];
         default:           dat_out = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_state       <= S_IDLE;
         r_shreg       <= '0;
         r_crc         <= '0;
         r_bit_cnt     <= '0;
         r_crc_cnt     <= '0;
         r_blk_words   <= '0;
         r_words_left  <= '0;
         r_blocks_left <= '0;
         r_gap_cnt     <= '0;
         r_pref        <= 1'b0;
         r_last_bit    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_blk_words   <= block_size[BLK_SIZE_W-1:2];
                  r_blocks_left <= block_count;
                  r_state       <= (block_count == 16'd0) ? S_FINISH : S_FETCH;
               end
            end
            S_FETCH: begin
               if (!fifo_empty) r_state <= S_START;
            end
            S_START: begin
               r_crc        <= '0;
               r_shreg      <= data_from_fifo;
               r_bit_cnt    <= 5'd31;
               r_words_left <= w_words_init;
               r_pref       <= 1'b0;
               r_state      <= S_DATA;
            end
            S_DATA: begin
               r_crc      <= w_crc_next;
               r_last_bit <= r_shreg[31];
               r_shreg    <= {r_shreg[30:0], 1'b0};
               if (w_pref_req) r_pref <= 1'b1;
               if (r_bit_cnt != 5'd0) begin
                  r_bit_cnt <= r_bit_cnt - 5'd1;
               end else if (r_words_left == '0) begin
                  r_crc_cnt <= 4'd15;
                  r_state   <= S_CRC;
               end else if (r_pref) begin
                  r_shreg      <= data_from_fifo;
                  r_bit_cnt    <= 5'd31;
                  r_words_left <= r_words_left - WW'(1);
                  r_pref       <= 1'b0;
               end else begin
                  r_state <= S_STALL;
               end
            end
            S_STALL: begin
               if (!fifo_empty) r_state <= S_RELOAD;
            end
            S_RELOAD: begin
               r_shreg      <= data_from_fifo;
               r_bit_cnt    <= 5'd31;
               r_words_left <= (r_words_left == '0) ? '0 : r_words_left - WW'(1);
               r_state      <= S_DATA;
            end
            S_CRC: begin
               r_crc <= {r_crc[14:0], 1'b0};
               if (r_crc_cnt == 4'd0) r_state <= S_END;
               else                   r_crc_cnt <= r_crc_cnt - 4'd1;
            end
            S_END: begin
               r_blocks_left <= (r_blocks_left == 16'd0) ? 16'd0 : r_blocks_left - 16'd1;
               if (r_blocks_left <= 16'd1) begin
                  r_state <= S_FINISH;
               end else if (GAP_CYCLES > 1) begin
                  // FETCH is itself an idle-high cycle, so GAP covers one fewer.
                  r_gap_cnt <= GW'(GAP_LOAD);
                  r_state   <= S_GAP;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == '0) r_state <= S_FETCH;
               else                 r_gap_cnt <= r_gap_cnt - GW'(1);
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

endmodule
